fetch_stage: RTL



---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 8-bit pipelined core.
// Loads the PC from the reset vector, assembles one- and two-byte
// instructions, and drives the IF/ID pipeline register. A two-byte
// instruction (IMM_OPCODE) is held across one cycle while its immediate
// byte is fetched, which leaves a single bubble in IF/ID.
module fetch_stage #(
   parameter logic [7:0] NOP_INSTR      = 8'h00,
   parameter logic [3:0] IMM_OPCODE     = 4'd12,
   parameter logic [7:0] RESET_VEC_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   input  logic       pc_en,
   input  logic       if_id_en,
   input  logic       flush,
   input  logic       BT,
   input  logic [7:0] branch_target,
   output logic [7:0] if_id_instr,
   output logic [7:0] if_id_imm,
   output logic [7:0] if_id_pc_plus1,
   output logic       if_id_valid,
   output logic [7:0] pc
);

   typedef enum logic [1:0] {
      ST_VEC = 2'd0,
      ST_RUN = 2'd1,
      ST_IMM = 2'd2
   } state_t;

   state_t     state_r, state_s;
   logic [7:0] pc_r, pc_s;
   logic [7:0] hold_r, hold_s;
   logic [7:0] instr_r, instr_s;
   logic [7:0] imm_r, imm_s;
   logic [7:0] pcp1_r, pcp1_s;
   logic       valid_r, valid_s;
   logic [7:0] imem_addr_s;
   logic [7:0] pc_plus1_s;

   assign pc_plus1_s = pc_r + 8'd1;   // 8-bit modulo: 0xFF wraps to 0x00

   // Next-state, next-PC and IF/ID load decisions; redirect beats stall beats advance.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      hold_s      = hold_r;
      instr_s     = instr_r;
      imm_s       = imm_r;
      pcp1_s      = pcp1_r;
      valid_s     = valid_r;
      imem_addr_s = pc_r;
      case (state_r)
         ST_VEC: begin
            // Reset-vector cycle: ignores enables and redirects, lasts one cycle.
            imem_addr_s = RESET_VEC_ADDR;
            pc_s        = imem_data;
            state_s     = ST_RUN;
            instr_s     = NOP_INSTR;
            imm_s       = 8'h00;
            valid_s     = 1'b0;
         end
         ST_RUN, ST_IMM: begin
            if (flush || BT) begin
               // Kill IF/ID and any half-fetched two-byte instruction.
               instr_s = NOP_INSTR;
               imm_s   = 8'h00;
               valid_s = 1'b0;
               hold_s  = 8'h00;
               state_s = ST_RUN;
               if (BT) begin
                  pc_s = branch_target;
               end else begin
                  pc_s = pc_r;
               end
            end else if (pc_en && if_id_en) begin
               if (state_r == ST_IMM) begin
                  // Second byte arrives: emit the assembled instruction.
                  instr_s = hold_r;
                  imm_s   = imem_data;
                  pcp1_s  = pc_plus1_s;
                  valid_s = 1'b1;
                  pc_s    = pc_plus1_s;
                  state_s = ST_RUN;
               end else if (imem_data[7:4] == IMM_OPCODE) begin
                  // First byte of a two-byte instruction: park it, bubble IF/ID.
                  hold_s  = imem_data;
                  pc_s    = pc_plus1_s;
                  state_s = ST_IMM;
                  instr_s = NOP_INSTR;
                  imm_s   = 8'h00;
                  valid_s = 1'b0;
               end else begin
                  instr_s = imem_data;
                  imm_s   = 8'h00;
                  pcp1_s  = pc_plus1_s;
                  valid_s = 1'b1;
                  pc_s    = pc_plus1_s;
               end
            end else begin
               // Stall: everything holds (defaults above).
               state_s = state_r;
            end
         end
         default: begin
            // Illegal encoding: recover through the reset-vector load.
            state_s = ST_VEC;
            instr_s = NOP_INSTR;
            imm_s   = 8'h00;
            valid_s = 1'b0;
            hold_s  = 8'h00;
         end
      endcase
   end

   // State, PC, hold byte and IF/ID register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_VEC;
         pc_r    <= 8'h00;
         hold_r  <= 8'h00;
         instr_r <= NOP_INSTR;
         imm_r   <= 8'h00;
         pcp1_r  <= 8'h00;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         hold_r  <= hold_s;
         instr_r <= instr_s;
         imm_r   <= imm_s;
         pcp1_r  <= pcp1_s;
         valid_r <= valid_s;
      end
   end

   assign imem_addr      = imem_addr_s;
   assign if_id_instr    = instr_r;
   assign if_id_imm      = imm_r;
   assign if_id_pc_plus1 = pcp1_r;
   assign if_id_valid    = valid_r;
   assign pc             = pc_r;

endmodule
